// File: rtl/amo_responder.sv
// Memory-side AMO responder: one atomic read-modify-write at a time on an internal
// 64-bit word array, with a single LR/SC reservation and a registered one-cycle ack.
module amo_responder #(
    parameter int DEPTH        = 256,
    parameter int RESV_GRANULE = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        amo_req_i,
    input  logic [3:0]  amo_op_i,
    input  logic [1:0]  amo_size_i,
    input  logic [63:0] amo_addr_i,
    input  logic [63:0] amo_data_i,
    output logic        amo_ack_o,
    output logic [63:0] amo_result_o,
    output logic        busy_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_ACK
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LR   = 4'd1,
        OP_SC   = 4'd2,
        OP_SWAP = 4'd3,
        OP_ADD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_MAX  = 4'd8,
        OP_MAXU = 4'd9,
        OP_MIN  = 4'd10,
        OP_MINU = 4'd11
    } amo_op_e;

    function automatic logic [63:0] alu64(amo_op_e op, logic [63:0] a, logic [63:0] b);
        logic [63:0] r;
        r = a;
        case (op)
            OP_SC, OP_SWAP: r = b;
            OP_ADD:         r = a + b;
            OP_AND:         r = a & b;
            OP_OR:          r = a | b;
            OP_XOR:         r = a ^ b;
            OP_MAX:         r = ($signed(a) > $signed(b)) ? a : b;
            OP_MAXU:        r = (a > b) ? a : b;
            OP_MIN:         r = ($signed(a) < $signed(b)) ? a : b;
            OP_MINU:        r = (a < b) ? a : b;
            default:        r = a;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] alu32(amo_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        r = a;
        case (op)
            OP_SC, OP_SWAP: r = b;
            OP_ADD:         r = a + b;
            OP_AND:         r = a & b;
            OP_OR:          r = a | b;
            OP_XOR:         r = a ^ b;
            OP_MAX:         r = ($signed(a) > $signed(b)) ? a : b;
            OP_MAXU:        r = (a > b) ? a : b;
            OP_MIN:         r = ($signed(a) < $signed(b)) ? a : b;
            OP_MINU:        r = (a < b) ? a : b;
            default:        r = a;
        endcase
        return r;
    endfunction

    state_e                 state_q, state_d;
    amo_op_e                op_q;
    logic                   word_q;
    logic [63:0]            addr_q;
    logic [63:0]            data_q;
    logic [63:0]            result_q;
    logic                   ack_q;
    logic                   resv_valid_q;
    logic [63:RESV_GRANULE] resv_addr_q;

    logic [63:0]            mem [DEPTH];
    logic [63:0]            rdata_q;
    logic [IDX_W-1:0]       idx;

    logic [31:0]            old_half;
    logic [31:0]            new_half;
    logic [63:0]            new_dword;
    logic [63:0]            new_value;
    logic [63:0]            old_value;
    logic                   resv_hit;
    logic                   wr_en;
    logic [63:0]            result_d;
    logic                   resv_set;
    logic                   resv_clr;
    logic                   unused_addr_bits;

    assign idx              = addr_q[3 +: IDX_W];
    assign unused_addr_bits = ^addr_q[1:0];

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (amo_req_i) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Word ops work on the half picked by addr[2]; the other half rides through unchanged.
    always_comb begin
        old_half  = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
        new_half  = alu32(op_q, old_half, data_q[31:0]);
        new_dword = alu64(op_q, rdata_q, data_q);
        if (word_q) begin
            new_value = addr_q[2] ? {new_half, rdata_q[31:0]} : {rdata_q[63:32], new_half};
            old_value = {{32{old_half[31]}}, old_half};
        end else begin
            new_value = new_dword;
            old_value = rdata_q;
        end
        resv_hit = resv_valid_q && (resv_addr_q == addr_q[63:RESV_GRANULE]);
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        wr_en    = 1'b0;
        result_d = '0;
        resv_set = 1'b0;
        resv_clr = 1'b0;
        case (op_q)
            OP_LR: begin
                result_d = old_value;
                resv_set = 1'b1;
            end
            OP_SC: begin
                wr_en    = resv_hit;
                result_d = resv_hit ? 64'd0 : 64'd1;
                resv_clr = 1'b1;
            end
            OP_SWAP, OP_ADD, OP_AND, OP_OR, OP_XOR,
            OP_MAX, OP_MAXU, OP_MIN, OP_MINU: begin
                wr_en    = 1'b1;
                result_d = old_value;
                resv_clr = resv_hit;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q         <= OP_NONE;
            word_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            result_q     <= '0;
            ack_q        <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            ack_q <= (state_q == S_ACK);
            if (state_q == S_IDLE && amo_req_i) begin
                op_q   <= (amo_op_i > 4'd11) ? OP_NONE : amo_op_e'(amo_op_i);
                word_q <= (amo_size_i == 2'b10);
                addr_q <= amo_addr_i;
                data_q <= amo_data_i;
            end
            if (state_q == S_WRITE) begin
                result_q <= result_d;
                if (resv_set) begin
                    resv_valid_q <= 1'b1;
                    resv_addr_q  <= addr_q[63:RESV_GRANULE];
                end else if (resv_clr) begin
                    resv_valid_q <= 1'b0;
                end
            end
        end
    end

    // NOTE: the backing array and its read register are deliberately left without reset;
    // contents survive rst_ni and map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (state_q == S_READ) rdata_q <= mem[idx];
        if (state_q == S_WRITE && wr_en) mem[idx] <= new_value;
    end

    assign amo_ack_o    = ack_q;
    assign amo_result_o = result_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_amo_responder.sv
// Directed bench for amo_responder: vector table for op semantics plus hand sequences
// for latency, reservation interplay, back-to-back requests and reset mid-op.
module tb_amo_responder;

    localparam logic [3:0] OP_NONE = 4'd0,  OP_LR  = 4'd1,  OP_SC   = 4'd2,  OP_SWAP = 4'd3,
                           OP_ADD  = 4'd4,  OP_AND = 4'd5,  OP_OR   = 4'd6,  OP_XOR  = 4'd7,
                           OP_MAX  = 4'd8,  OP_MAXU = 4'd9, OP_MIN  = 4'd10, OP_MINU = 4'd11;
    localparam logic [1:0] SZ_W = 2'b10, SZ_D = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        amo_req_i = 1'b0;
    logic [3:0]  amo_op_i = '0;
    logic [1:0]  amo_size_i = '0;
    logic [63:0] amo_addr_i = '0;
    logic [63:0] amo_data_i = '0;
    logic        amo_ack_o;
    logic [63:0] amo_result_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    amo_responder #(.DEPTH(256), .RESV_GRANULE(3)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .amo_req_i    (amo_req_i),
        .amo_op_i     (amo_op_i),
        .amo_size_i   (amo_size_i),
        .amo_addr_i   (amo_addr_i),
        .amo_data_i   (amo_data_i),
        .amo_ack_o    (amo_ack_o),
        .amo_result_o (amo_result_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] data;
        logic        chk;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Drives one request and waits for its ack; lat counts negedges from the sampling edge.
    task automatic do_op(input logic [3:0] op, input logic [1:0] sz, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] res, output int lat,
                         output logic busy_ok);
        @(negedge clk_i);
        amo_req_i  = 1'b1;
        amo_op_i   = op;
        amo_size_i = sz;
        amo_addr_i = a;
        amo_data_i = d;
        lat        = 0;
        busy_ok    = 1'b1;
        res        = '0;
        forever begin
            @(negedge clk_i);
            lat++;
            if (amo_ack_o) begin
                if (busy_o) busy_ok = 1'b0;
                res = amo_result_o;
                break;
            end
            if (!busy_o) busy_ok = 1'b0;
            if (lat > 20) begin
                failures++;
                $display("FAIL timeout: no ack for op %0d within 20 cycles", op);
                break;
            end
        end
        amo_req_i = 1'b0;
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [1:0] sz,
                       input logic [63:0] a, input logic [63:0] d, input logic [63:0] exp);
        logic [63:0] res;
        int          lat;
        logic        bok;
        do_op(op, sz, a, d, res, lat, bok);
        check(name, res, exp);
    endtask

    task automatic setw(input logic [63:0] a, input logic [63:0] d);
        logic [63:0] res;
        int          lat;
        logic        bok;
        do_op(OP_SWAP, SZ_D, a, d, res, lat, bok);
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        logic        bok;
        int          ack_cnt;
        int          ack_at[2];
        logic [63:0] ack_res[2];

        // Reset values
        repeat (3) @(negedge clk_i);
        check("rst_ack", {63'd0, amo_ack_o}, 64'd0);
        check("rst_result", amo_result_o, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Dword ADD: latency, busy window, result, writeback
        setw(64'h20, 64'd5);
        do_op(OP_ADD, SZ_D, 64'h20, 64'd3, res, lat, bok);
        check("add_latency", 64'(lat), 64'd4);
        check("add_busy_window", {63'd0, bok}, 64'd1);
        check("add_result", res, 64'd5);
        run("add_mem", OP_OR, SZ_D, 64'h20, 64'd0, 64'd8);

        vecs.push_back('{OP_SWAP, SZ_D, 64'h08, 64'hFFFF_FFFF_0000_0001, 1'b0, 64'h0});
        vecs.push_back('{OP_ADD,  SZ_W, 64'h0C, 64'h1,                   1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{OP_OR,   SZ_D, 64'h08, 64'h0,                   1'b1, 64'h0000_0000_0000_0001});
        vecs.push_back('{OP_SWAP, SZ_D, 64'h40, 64'h1234,                1'b0, 64'h0});
        vecs.push_back('{OP_LR,   SZ_D, 64'h40, 64'h0,                   1'b1, 64'h1234});
        vecs.push_back('{OP_SC,   SZ_D, 64'h40, 64'hAB,                  1'b1, 64'h0});
        vecs.push_back('{OP_OR,   SZ_D, 64'h40, 64'h0,                   1'b1, 64'hAB});
        vecs.push_back('{OP_SC,   SZ_D, 64'h40, 64'hCD,                  1'b1, 64'h1});
        vecs.push_back('{OP_OR,   SZ_D, 64'h40, 64'h0,                   1'b1, 64'hAB});
        vecs.push_back('{OP_SWAP, SZ_D, 64'h00, 64'hDEAD_BEEF_0000_0005, 1'b0, 64'h0});
        vecs.push_back('{OP_MIN,  SZ_W, 64'h00, 64'hFFFF_FFFE,           1'b1, 64'h5});
        vecs.push_back('{OP_OR,   SZ_D, 64'h00, 64'h0,                   1'b1, 64'hDEAD_BEEF_FFFF_FFFE});
        vecs.push_back('{OP_SWAP, SZ_D, 64'h00, 64'hDEAD_BEEF_0000_0005, 1'b1, 64'hDEAD_BEEF_FFFF_FFFE});
        vecs.push_back('{OP_MINU, SZ_W, 64'h00, 64'hFFFF_FFFE,           1'b1, 64'h5});
        vecs.push_back('{OP_OR,   SZ_D, 64'h00, 64'h0,                   1'b1, 64'hDEAD_BEEF_0000_0005});
        vecs.push_back('{OP_MAX,  SZ_W, 64'h04, 64'h1,                   1'b1, 64'hFFFF_FFFF_DEAD_BEEF});
        vecs.push_back('{OP_OR,   SZ_D, 64'h00, 64'h0,                   1'b1, 64'h0000_0001_0000_0005});
        vecs.push_back('{OP_MAXU, SZ_D, 64'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0000_0001_0000_0005});
        vecs.push_back('{OP_XOR,  SZ_D, 64'h00, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{OP_AND,  SZ_D, 64'h00, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0});
        vecs.push_back('{OP_ADD,  SZ_D, 64'h00, 64'h1000_0000_0000_0000, 1'b1, 64'hF000_F000_F000_F000});
        vecs.push_back('{OP_OR,   SZ_D, 64'h00, 64'h0,                   1'b1, 64'h0000_F000_F000_F000});
        vecs.push_back('{OP_NONE, SZ_D, 64'h00, 64'h1234,                1'b1, 64'h0});
        vecs.push_back('{4'd13,   SZ_D, 64'h00, 64'h1234,                1'b1, 64'h0});
        vecs.push_back('{OP_OR,   SZ_D, 64'h00, 64'h0,                   1'b1, 64'h0000_F000_F000_F000});
        vecs.push_back('{OP_MIN,  SZ_D, 64'h00, 64'h8000_0000_0000_0000, 1'b1, 64'h0000_F000_F000_F000});
        vecs.push_back('{OP_ADD,  2'b00, 64'h00, 64'h1,                  1'b1, 64'h8000_0000_0000_0000});
        vecs.push_back('{OP_OR,   SZ_D, 64'h00, 64'h0,                   1'b1, 64'h8000_0000_0000_0001});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].data, res, lat, bok);
            if (vecs[i].chk) check($sformatf("vec%0d", i), res, vecs[i].exp);
        end

        // A store to the reserved granule kills the reservation
        run("lr_after_sc", OP_LR, SZ_D, 64'h40, 64'h0, 64'hAB);
        run("swap_resv", OP_SWAP, SZ_D, 64'h40, 64'd7, 64'hAB);
        run("sc_killed", OP_SC, SZ_D, 64'h40, 64'd9, 64'd1);
        run("sc_killed_mem", OP_OR, SZ_D, 64'h40, 64'd0, 64'd7);
        run("lr_again", OP_LR, SZ_D, 64'h40, 64'h0, 64'd7);
        setw(64'h48, 64'h11);
        run("sc_other_granule", OP_SC, SZ_D, 64'h40, 64'd9, 64'd0);
        run("sc_other_mem", OP_OR, SZ_D, 64'h40, 64'd0, 64'd9);

        // Request held high across the ack: back-to-back NONE ops
        @(negedge clk_i);
        amo_req_i  = 1'b1;
        amo_op_i   = OP_NONE;
        amo_size_i = SZ_D;
        amo_addr_i = 64'h40;
        amo_data_i = 64'hFFFF;
        ack_cnt    = 0;
        ack_at     = '{0, 0};
        ack_res    = '{64'hX, 64'hX};
        for (int c = 1; c <= 20 && ack_cnt < 2; c++) begin
            @(negedge clk_i);
            if (amo_ack_o) begin
                ack_at[ack_cnt]  = c;
                ack_res[ack_cnt] = amo_result_o;
                ack_cnt++;
            end
        end
        amo_req_i = 1'b0;
        check("b2b_ack_count", 64'(ack_cnt), 64'd2);
        check("b2b_first_at", 64'(ack_at[0]), 64'd4);
        check("b2b_second_at", 64'(ack_at[1]), 64'd8);
        check("b2b_res0", ack_res[0], 64'd0);
        check("b2b_res1", ack_res[1], 64'd0);
        run("b2b_mem", OP_OR, SZ_D, 64'h40, 64'd0, 64'd9);

        // Reset asserted during READ of a SWAP: no ack, no write
        setw(64'h30, 64'h55);
        @(negedge clk_i);
        amo_req_i  = 1'b1;
        amo_op_i   = OP_SWAP;
        amo_size_i = SZ_D;
        amo_addr_i = 64'h30;
        amo_data_i = 64'h99;
        @(negedge clk_i);
        check("midop_in_read", {63'd0, busy_o}, 64'd1);
        rst_ni    = 1'b0;
        amo_req_i = 1'b0;
        #1;
        check("midop_busy_cleared", {63'd0, busy_o}, 64'd0);
        ack_cnt = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (amo_ack_o) ack_cnt++;
        end
        check("midop_no_ack", 64'(ack_cnt), 64'd0);
        run("midop_mem", OP_OR, SZ_D, 64'h30, 64'd0, 64'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
